fetch_unit: RTL and testbench

Instruction fetch stage for the simple 8-bit CPU. It owns the 6-bit program counter and drives the instruction ROM's `addr`/`read`/`ena` pins in a fixed setup-then-read sequence. It latches the returned 8-bit instruction word into an instruction register and hands it to the execute/decode stage through a valid/ready handshake. It also accepts jump redirects from execute.

---
 rtl/fetch_unit_if.sv | 28 ++
 rtl/fetch_unit.sv | 77 +++++++
 tb/tb_fetch_unit.sv | 209 ++++++++++++++++++++
 3 files changed

// File: rtl/fetch_unit_if.sv
// fetch_unit_if: ROM pins plus the instruction handshake and jump redirect
// between the fetch stage (master) and the ROM/execute side (slave).
interface fetch_unit_if #(
    parameter int ADDR_W = 6,
    parameter int DATA_W = 8
);
    logic [ADDR_W-1:0] rom_addr;
    logic              rom_ena;
    logic              rom_read;
    logic [DATA_W-1:0] rom_data;
    logic [DATA_W-1:0] ir;
    logic              ir_valid;
    logic              ir_ready;
    logic              jump_en;
    logic [ADDR_W-1:0] jump_addr;

    // Fetch stage: drives the ROM pins and the instruction register side.
    modport master (
        output rom_addr, rom_ena, rom_read, ir, ir_valid,
        input  rom_data, ir_ready, jump_en, jump_addr
    );

    // ROM and execute stage: return data, consume instructions, redirect.
    modport slave (
        input  rom_addr, rom_ena, rom_read, ir, ir_valid,
        output rom_data, ir_ready, jump_en, jump_addr
    );
endinterface

// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch stage. Walks the ROM through an address
// setup cycle and a read cycle, captures the word into the instruction
// register and offers it to execute with a valid/ready handshake. The PC
// advances on capture and may be redirected when execute accepts.
module fetch_unit #(
    parameter int ADDR_W = 6,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              run,
    fetch_unit_if.master      bus,
    output logic [ADDR_W-1:0] pc
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        READ = 2'd2,
        HOLD = 2'd3
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic              accept;
    logic [DATA_W-1:0] ir_q;

    // Execute takes the held word; only meaningful in HOLD.
    assign accept = (state == HOLD) && bus.ir_ready;

    // State register; reset forces IDLE immediately, aborting any fetch.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples the pre-edge values of the others.
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode: run is only looked at in IDLE and on accept, so
    // dropping it mid-fetch lets the current word complete.
    always_comb begin
        // NOTE: default assigned first so every path drives state_nxt and
        // no latch is inferred.
        state_nxt = state;
        case (state)
            IDLE:    if (run) state_nxt = ADDR;
            ADDR:    state_nxt = READ;
            READ:    state_nxt = HOLD;
            HOLD:    if (bus.ir_ready) state_nxt = run ? ADDR : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // PC and instruction register: capture and increment on the READ edge,
    // redirect only on an accepting HOLD edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc   <= '0;
            ir_q <= '0;
        end else if (state == READ) begin
            ir_q <= bus.rom_data;
            pc   <= pc + ADDR_W'(1);
        end else if (accept && bus.jump_en) begin
            pc   <= bus.jump_addr;
        end
    end

    // Moore decode straight from the state register keeps the ROM strobes
    // glitch-free; read is a subset of ena by construction.
    assign bus.rom_ena  = (state == ADDR) || (state == READ);
    assign bus.rom_read = (state == READ);
    assign bus.rom_addr = pc;
    assign bus.ir       = ir_q;
    assign bus.ir_valid = (state == HOLD);
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed, cycle-exact bench for fetch_unit. Outputs are
// sampled 1 time unit after each rising edge; inputs change at that point too.
module tb_fetch_unit;
    localparam int ADDR_W = 6;
    localparam int DATA_W = 8;

    logic              clk;
    logic              rst;
    logic              run;
    logic [ADDR_W-1:0] pc;
    logic [DATA_W-1:0] rom [64];

    int n_vec = 0;
    int n_err = 0;

    fetch_unit_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    fetch_unit #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk (clk),
        .rst (rst),
        .run (run),
        .bus (bus),
        .pc  (pc)
    );

    // ROM model: drives data only during a read, and address 63 floats.
    assign bus.rom_data = (bus.rom_read && bus.rom_ena && bus.rom_addr != 6'd63)
                          ? rom[bus.rom_addr] : 'z;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Strobes, valid and address for an ADDR/READ/IDLE-type cycle.
    task automatic chk_phase(input string tag, input logic ena, input logic rd,
                             input logic vld, input logic [ADDR_W-1:0] addr);
        chk({tag, ".ena"},   32'(bus.rom_ena),  32'(ena));
        chk({tag, ".read"},  32'(bus.rom_read), 32'(rd));
        chk({tag, ".valid"}, 32'(bus.ir_valid), 32'(vld));
        chk({tag, ".addr"},  32'(bus.rom_addr), 32'(addr));
    endtask

    // HOLD cycle: word offered, ROM idle.
    task automatic chk_hold(input string tag, input logic [DATA_W-1:0] ir_e,
                            input logic [ADDR_W-1:0] pc_e);
        chk({tag, ".valid"}, 32'(bus.ir_valid), 32'(1'b1));
        chk({tag, ".ena"},   32'(bus.rom_ena),  32'(1'b0));
        chk({tag, ".read"},  32'(bus.rom_read), 32'(1'b0));
        chk({tag, ".ir"},    32'(bus.ir),       32'(ir_e));
        chk({tag, ".pc"},    32'(pc),           32'(pc_e));
    endtask

    initial begin
        for (int i = 0; i < 64; i++) begin
            if (i < 4)      rom[i] = 8'h43;
            else if (i < 8) rom[i] = 8'hC3;
            else            rom[i] = 8'(8'h10 + i);
        end

        // ---- Reset state ----
        rst = 1'b1;
        run = 1'b0;
        bus.ir_ready  = 1'b0;
        bus.jump_en   = 1'b0;
        bus.jump_addr = '0;
        step();
        step();
        chk_phase("rst0", 1'b0, 1'b0, 1'b0, 6'd0);
        chk("rst0.pc", 32'(pc),     32'd0);
        chk("rst0.ir", 32'(bus.ir), 32'd0);
        rst = 1'b0;
        step();
        step();
        chk_phase("idle_norun", 1'b0, 1'b0, 1'b0, 6'd0);

        // ---- Sequential fetch, 3 cycles per word ----
        run = 1'b1;
        bus.ir_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            step();
            chk_phase($sformatf("seq%0d.addr_ph", k), 1'b1, 1'b0, 1'b0, 6'(k));
            step();
            chk_phase($sformatf("seq%0d.read_ph", k), 1'b1, 1'b1, 1'b0, 6'(k));
            chk($sformatf("seq%0d.read_wo_ena", k),
                32'(bus.rom_read & ~bus.rom_ena), 32'd0);
            step();
            chk_hold($sformatf("seq%0d.hold", k), (k < 4) ? 8'h43 : 8'hC3, 6'(k + 1));
        end

        // ---- Reset mid-READ with pc=5 ----
        bus.jump_en   = 1'b1;
        bus.jump_addr = 6'd5;
        step();
        chk_phase("jmp5.addr_ph", 1'b1, 1'b0, 1'b0, 6'd5);
        bus.jump_en = 1'b0;
        step();
        chk_phase("jmp5.read_ph", 1'b1, 1'b1, 1'b0, 6'd5);
        run = 1'b0;
        rst = 1'b1;
        #1;
        chk_phase("rst_mid", 1'b0, 1'b0, 1'b0, 6'd0);
        chk("rst_mid.pc", 32'(pc),     32'd0);
        chk("rst_mid.ir", 32'(bus.ir), 32'd0);
        step();
        rst = 1'b0;
        step();
        step();
        chk_phase("rst_idle", 1'b0, 1'b0, 1'b0, 6'd0);

        // ---- Backpressure ----
        run = 1'b1;
        bus.ir_ready = 1'b0;
        step();
        step();
        step();
        chk_hold("bp.first", 8'h43, 6'd1);
        for (int c = 0; c < 4; c++) begin
            step();
            chk_hold($sformatf("bp.stall%0d", c), 8'h43, 6'd1);
        end
        bus.ir_ready = 1'b1;
        step();
        chk_phase("bp.resume", 1'b1, 1'b0, 1'b0, 6'd1);
        chk("bp.ir_kept", 32'(bus.ir), 32'h43);
        step();
        chk_phase("bp.read_ph", 1'b1, 1'b1, 1'b0, 6'd1);

        // ---- jump_en pulse during READ is ignored ----
        bus.jump_en   = 1'b1;
        bus.jump_addr = 6'd20;
        step();
        bus.jump_en = 1'b0;
        chk_hold("jread.hold", 8'h43, 6'd2);
        step();
        chk_phase("jread.next", 1'b1, 1'b0, 1'b0, 6'd2);

        // ---- Jump on accept of the word at address 2 ----
        step();
        step();
        chk_hold("jmp.src", 8'h43, 6'd3);
        bus.jump_en   = 1'b1;
        bus.jump_addr = 6'd6;
        step();
        bus.jump_en = 1'b0;
        chk_phase("jmp.addr_ph", 1'b1, 1'b0, 1'b0, 6'd6);
        step();
        step();
        chk_hold("jmp.dst", 8'hC3, 6'd7);

        // ---- Wrap-around from 63 ----
        bus.jump_en   = 1'b1;
        bus.jump_addr = 6'd63;
        step();
        bus.jump_en = 1'b0;
        chk_phase("wrap.addr_ph", 1'b1, 1'b0, 1'b0, 6'd63);
        step();
        step();
        chk("wrap.pc",    32'(pc),           32'd0);
        chk("wrap.valid", 32'(bus.ir_valid), 32'd1);
        step();
        chk_phase("wrap.next", 1'b1, 1'b0, 1'b0, 6'd0);
        step();
        step();
        chk_hold("wrap.word0", 8'h43, 6'd1);

        // ---- Run gating: drop run during READ ----
        step();
        step();
        chk_phase("gate.read_ph", 1'b1, 1'b1, 1'b0, 6'd1);
        run = 1'b0;
        step();
        chk_hold("gate.delivered", 8'h43, 6'd2);
        step();
        chk_phase("gate.idle", 1'b0, 1'b0, 1'b0, 6'd2);
        step();
        chk_phase("gate.idle2", 1'b0, 1'b0, 1'b0, 6'd2);
        run = 1'b1;
        step();
        chk_phase("gate.resume", 1'b1, 1'b0, 1'b0, 6'd2);
        step();
        step();
        chk_hold("gate.word2", 8'h43, 6'd3);

        // ---- Jump to the current pc refetches the same word ----
        bus.jump_en   = 1'b1;
        bus.jump_addr = 6'd3;
        step();
        bus.jump_en = 1'b0;
        chk_phase("self.addr_ph", 1'b1, 1'b0, 1'b0, 6'd3);
        step();
        step();
        chk_hold("self.word3", 8'h43, 6'd4);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
